// File: rtl/usb_fifo_stream_ctrl.sv
// FX2LP synchronous slave-FIFO controller: bursts EP2 words onto an rx stream,
// kicks the processing core, then streams its result words into EP6.
module usb_fifo_stream_ctrl #(
    parameter int DATA_W     = 16,
    parameter int RD_WORDS   = 18,
    parameter int WR_WORDS   = 4,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 255,
    parameter int AUTO_LOOP  = 1,
    parameter int USE_PKTEND = 1
) (
    input  logic              CLKOUT,
    input  logic              rst,
    input  logic              start,
    input  logic              FLAGA,
    input  logic              FLAGD,
    output logic              SLRD,
    output logic              SLWR,
    output logic              SLOE,
    output logic              PKTEND,
    output logic              IFCLK,
    output logic [1:0]        FIFOADR,
    inout  wire  [DATA_W-1:0] FDATA,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              proc_start,
    input  logic              proc_done,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              timeout_err,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam int PCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_PROC = 3'd2,
        S_WR   = 3'd3,
        S_PKT  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t             state_q;
    logic [PCNT_W-1:0]  proc_cnt;
    logic               rd_stb;
    logic               wr_stb;
    logic               pk_stb;

    // Strobes are gated by rst so nothing reaches the FIFO in the reset cycle.
    assign rd_stb = (state_q == S_RD) && FLAGA && (rd_cnt < CNT_W'(RD_WORDS)) && !rst;
    assign wr_stb = (state_q == S_WR) && FLAGD && tx_valid && (wr_cnt < CNT_W'(WR_WORDS)) && !rst;
    assign pk_stb = (state_q == S_PKT) && FLAGD && !rst;

    assign SLRD     = ~rd_stb;
    assign SLWR     = ~wr_stb;
    assign PKTEND   = ~pk_stb;
    assign SLOE     = ~((state_q == S_RD) && !rst);
    assign tx_ready = wr_stb;
    assign IFCLK    = ~CLKOUT;
    assign FIFOADR  = (state_q == S_PROC || state_q == S_WR || state_q == S_PKT) ? 2'b10 : 2'b00;
    assign FDATA    = wr_stb ? tx_data : 'z;
    assign busy     = (state_q != S_IDLE);
    assign state    = state_q;

    always_ff @(posedge CLKOUT) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            proc_start  <= 1'b0;
            proc_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            proc_start <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    rd_cnt <= '0;
                    wr_cnt <= '0;
                    if (AUTO_LOOP != 0 || start) begin
                        timeout_err <= 1'b0;
                        state_q     <= S_RD;
                    end
                end
                S_RD: begin
                    if (rd_stb) begin
                        rx_data  <= FDATA;
                        rx_valid <= 1'b1;
                        rd_cnt   <= rd_cnt + 1'b1;
                        if (rd_cnt == CNT_W'(RD_WORDS - 1)) begin
                            proc_start <= 1'b1;
                            proc_cnt   <= '0;
                            state_q    <= S_PROC;
                        end
                    end
                end
                S_PROC: begin
                    // A done arriving in the timeout cycle still wins.
                    if (proc_done) begin
                        state_q <= S_WR;
                    end else if (TIMEOUT != 0 && proc_cnt == PCNT_W'(TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        proc_cnt <= proc_cnt + 1'b1;
                    end
                end
                S_WR: begin
                    if (wr_stb) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == CNT_W'(WR_WORDS - 1))
                            state_q <= (USE_PKTEND != 0) ? S_PKT : S_DONE;
                    end
                end
                S_PKT: begin
                    if (FLAGD)
                        state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
